// File: rtl/toggle_event_decoder_pkg.sv
// Shared definitions for the toggle-encoded event link receiver: default widths,
// the pending-buffer state enum and the reset reference level of the toggle line.
package toggle_event_decoder_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PEND_W      = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_FILT_LEN    = 3;

  // Power-up Q of the upstream T flip-flop; both link ends start from this level.
  localparam logic TOG_RESET_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2
  } pend_state_e;

  function automatic pend_state_e pend_state(input logic is_zero, input logic is_max);
    if (is_zero) return EMPTY;
    if (is_max)  return FULL;
    return PENDING;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser bringing the asynchronous toggle level into clk.
// All stages reset to the link's reference level so no spurious change is seen.
module toggle_sync
  import toggle_event_decoder_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{TOG_RESET_LEVEL}};
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive end of a toggle-encoded event link: synchronise, detect each level change,
// pulse once per change, buffer events behind valid/ready and count them.
// Optional glitch filter: define TOGGLE_DECODER_GLITCH_FILTER_EN.
module toggle_event_decoder
  import toggle_event_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PEND_W      = DEF_PEND_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tog_in,
  output logic              pulse_out,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  evt_total,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("toggle_event_decoder: SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("toggle_event_decoder: FILT_LEN must be at least 1");
  end

  logic        tog_s;
  logic        lvl;
  logic        tog_q;
  logic        edge_det;
  logic        pop;
  logic        ovf_set;
  logic [PEND_W-1:0] pend_nxt;
  pend_state_e state;

  toggle_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tog_in),
    .q     (tog_s)
  );

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

  logic [FCW-1:0] filt_cnt;
  logic           acc_lvl;

  // The accepted level moves only on the FILT_LEN-th consecutive differing sample;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      acc_lvl  <= TOG_RESET_LEVEL;
    end else if (tog_s != acc_lvl) begin
      if (filt_cnt == FILT_LAST) begin
        filt_cnt <= '0;
        acc_lvl  <= tog_s;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign lvl = acc_lvl;
`else
  assign lvl = tog_s;
`endif

  // Either direction of change is one event.
  assign edge_det = lvl ^ tog_q;

  // Pending buffer state is a pure decode of the count.
  assign state = pend_state(pend_cnt == '0, pend_cnt == PEND_MAX);

  always_comb begin
    evt_valid = (state != EMPTY);
  end

  assign pop = evt_valid & evt_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    pend_nxt = pend_cnt;
    ovf_set  = 1'b0;
    case ({edge_det, pop})
      2'b10: begin
        if (state == FULL) ovf_set  = 1'b1;
        else               pend_nxt = pend_cnt + PEND_W'(1);
      end
      2'b01:   pend_nxt = pend_cnt - PEND_W'(1);
      default: pend_nxt = pend_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q     <= TOG_RESET_LEVEL;
      pulse_out <= 1'b0;
      pend_cnt  <= '0;
      evt_total <= '0;
      overflow  <= 1'b0;
    end else begin
      tog_q     <= lvl;
      pulse_out <= edge_det;
      pend_cnt  <= pend_nxt;
      evt_total <= evt_total + CNT_W'(edge_det);
      // A fresh drop outranks a simultaneous clear.
      overflow  <= ovf_set | (overflow & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder with a sample-history reference model
// compared every cycle, plus literal expectations at the key points.
module tb_toggle_event_decoder;

  localparam int S      = 2;
  localparam int PEND_W = 4;
  localparam int CNT_W  = 16;
  localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  localparam int F   = 3;
  localparam int LAT = S + 1 + F;
  localparam int SP  = F + 1;
`else
  localparam int LAT = S + 1;
  localparam int SP  = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tog_in;
  logic              pulse_out;
  logic              evt_valid;
  logic              evt_ready;
  logic [PEND_W-1:0] pend_cnt;
  logic [CNT_W-1:0]  evt_total;
  logic              overflow;
  logic              clr_ovf;

  int n_checks = 0;
  int n_bad    = 0;

  toggle_event_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tog_in    (tog_in),
    .pulse_out (pulse_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pend_cnt  (pend_cnt),
    .evt_total (evt_total),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events are derived from the history of tog_in samples taken at
  // each clock since reset; a change in the sample stream shows up S edges later.
  bit               hist[$];
  int               m_pend  = 0;
  logic [CNT_W-1:0] m_total = '0;
  bit               m_ovf   = 1'b0;
  bit               m_pulse = 1'b0;
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  bit m_acc       = 1'b0;
  bit m_flip      = 1'b0;
  int m_last_flip = -1;
`endif

  function automatic bit samp(input int i);
    if (i < 0 || i >= hist.size()) return 1'b0;
    return hist[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  k;
    bit  ev;
    bit  pop;
    bit  ovf_evt;
    bit  all_diff;
    if (!rst_n) begin
      hist.delete();
      m_pend  = 0;
      m_total = '0;
      m_ovf   = 1'b0;
      m_pulse = 1'b0;
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
      m_acc       = 1'b0;
      m_flip      = 1'b0;
      m_last_flip = -1;
`endif
    end else begin
      k = hist.size();
      hist.push_back(tog_in);
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
      // Accepted level flips once F consecutive synchronised samples since the
      // last flip all disagree with it; the event is seen one edge later.
      ev     = m_flip;
      m_flip = 1'b0;
      if (k - F + 1 > m_last_flip && k - F + 1 >= 0) begin
        all_diff = 1'b1;
        for (int j = 0; j < F; j++)
          if (samp(k - j - S) == m_acc) all_diff = 1'b0;
        if (all_diff) begin
          m_acc       = ~m_acc;
          m_flip      = 1'b1;
          m_last_flip = k;
        end
      end
`else
      all_diff = 1'b0;
      ev = (samp(k - S) != samp(k - S - 1));
`endif
      pop     = evt_ready && (m_pend != 0);
      ovf_evt = ev && !pop && (m_pend == PMAX);
      m_pulse = ev;
      if (ev) m_total = m_total + 1'b1;
      if (ev && !pop && m_pend != PMAX) m_pend++;
      else if (pop && !ev)              m_pend--;
      if (ovf_evt)      m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cyc_pulse", 32'(pulse_out), 32'(m_pulse));
      check("cyc_pend",  32'(pend_cnt),  32'(m_pend));
      check("cyc_valid", 32'(evt_valid), 32'(m_pend != 0));
      check("cyc_total", 32'(evt_total), 32'(m_total));
      check("cyc_ovf",   32'(overflow),  32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    rst_n  = 1'b0;
    tog_in = lvl;
    repeat (2) tick();
    rst_n  = 1'b1;
  endtask

  task automatic toggles(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tog_in = ~tog_in;
      repeat (gap) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; tog_in = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    check("rst_pulse", 32'(pulse_out), 0);
    check("rst_pend",  32'(pend_cnt),  0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_total", 32'(evt_total), 0);
    check("rst_ovf",   32'(overflow),  0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single 0->1 change: one pulse LAT edges later.
    tog_in = 1'b1;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      check("t1_pulse", 32'(pulse_out), 32'(i == LAT));
    end
    check("t1_pend",  32'(pend_cnt),  1);
    check("t1_valid", 32'(evt_valid), 1);
    check("t1_total", 32'(evt_total), 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("t1_drain", 32'(pend_cnt), 0);

    // Five buffered events, then drained one per cycle.
    toggles(5, 4 > SP ? 4 : SP);
    repeat (LAT) tick();
    check("t2_pend",  32'(pend_cnt),  5);
    check("t2_total", 32'(evt_total), 6);
    evt_ready = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("t2_drain_pend",  32'(pend_cnt),  32'(i));
      check("t2_drain_valid", 32'(evt_valid), 32'(i != 0));
    end
    tick();
    check("t2_empty_ready", 32'(pend_cnt), 0);
    evt_ready = 1'b0;

    // Saturation at PMAX and overflow set / clear.
    do_reset(1'b0);
    repeat (2) tick();
    toggles(16, SP);
    repeat (LAT) tick();
    check("t3_pend",  32'(pend_cnt),  15);
    check("t3_ovf",   32'(overflow),  1);
    check("t3_total", 32'(evt_total), 16);
    check("t3_valid", 32'(evt_valid), 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t3_clr", 32'(overflow), 0);

    // FULL: event and pop in the same cycle leave the count alone, no overflow.
    tog_in = ~tog_in;
    repeat (LAT - 1) tick();
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("t4_pulse", 32'(pulse_out), 1);
    check("t4_pend",  32'(pend_cnt),  15);
    check("t4_ovf",   32'(overflow),  0);
    repeat (SP) tick();

    // FULL: clear and a new drop in the same cycle, set wins.
    tog_in = ~tog_in;
    repeat (LAT - 1) tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t4b_pulse", 32'(pulse_out), 1);
    check("t4b_ovf",   32'(overflow),  1);
    check("t4b_pend",  32'(pend_cnt),  15);
    repeat (SP) tick();

    // Reset mid-operation with 7 pending and a pulse in flight.
    do_reset(1'b0);
    repeat (2) tick();
    toggles(7, SP);
    repeat (LAT) tick();
    check("t5_pend", 32'(pend_cnt), 7);
    tog_in = ~tog_in;
    repeat (LAT - 1) tick();
    rst_n  = 1'b0;
    tog_in = 1'b1;
    #1;
    check("t5_rst_pulse", 32'(pulse_out), 0);
    check("t5_rst_pend",  32'(pend_cnt),  0);
    check("t5_rst_valid", 32'(evt_valid), 0);
    check("t5_rst_total", 32'(evt_total), 0);
    check("t5_rst_ovf",   32'(overflow),  0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_pulse", 32'(pulse_out), 0);
    end
    rst_n = 1'b1;
    // A level of 1 at release differs from the reference 0: exactly one event.
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      check("t5_rel_pulse", 32'(pulse_out), 32'(i == LAT));
    end
    check("t5_rel_total", 32'(evt_total), 1);
    check("t5_rel_pend",  32'(pend_cnt),  1);

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
    // Two-cycle excursion is filtered; a held change is accepted after LAT.
    tog_in = 1'b0; tick(); tick(); tog_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_glitch_pulse", 32'(pulse_out), 0);
    end
    check("t6_glitch_total", 32'(evt_total), 1);
    tog_in = 1'b0;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      check("t6_held_pulse", 32'(pulse_out), 32'(i == LAT));
    end
    check("t6_held_total", 32'(evt_total), 2);
`else
    // Wrap of the running total: a burst of single-cycle levels, which the
    // synchronous stimulus makes deterministic, fills it to all ones.
    do_reset(1'b0);
    repeat (2) tick();
    evt_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      tog_in = ~tog_in;
      tick();
    end
    repeat (LAT + 1) tick();
    check("t7_total_max", 32'(evt_total), 32'h0000_FFFF);
    tog_in = ~tog_in;
    repeat (LAT + 1) tick();
    check("t7_total_wrap", 32'(evt_total), 0);
    check("t7_pend",       32'(pend_cnt),  0);
    evt_ready = 1'b0;
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
